// File: rtl/uart_rx_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_if
// Purpose  : Serial line, tick enable and received-word bundle for uart_rx.
// Revision : 1.0
// ============================================================================
interface uart_rx_if #(
    parameter int DBIT = 8
);
    logic            s_tick;
    logic            rx;
    logic [DBIT-1:0] rx_dout;
    logic            rx_done_tick;
    logic            frame_err;

    modport master (
        output s_tick,
        output rx,
        input  rx_dout,
        input  rx_done_tick,
        input  frame_err
    );

    modport slave (
        input  s_tick,
        input  rx,
        output rx_dout,
        output rx_done_tick,
        output frame_err
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Purpose  : 16x-oversampling UART receiver with framing-error flag.
// Revision : 1.0
// ============================================================================
module uart_rx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  wire logic  clk,
    input  wire logic  reset,
    uart_rx_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    localparam logic [4:0] c_s_mid     = 5'd7;
    localparam logic [4:0] c_s_bit     = 5'd15;
    localparam logic [4:0] c_s_stop    = 5'(SB_TICK - 1);
    localparam logic [2:0] c_n_last    = 3'(DBIT - 1);

    state_t          r_state;
    state_t          w_state_next;
    logic [4:0]      r_s;
    logic [4:0]      w_s_next;
    logic [2:0]      r_n;
    logic [2:0]      w_n_next;
    logic [DBIT-1:0] r_b;
    logic [DBIT-1:0] w_b_next;
    logic [DBIT-1:0] r_dout;
    logic [DBIT-1:0] w_dout_next;
    logic            r_done;
    logic            w_done_next;
    logic            r_ferr;
    logic            w_ferr_next;
    logic            r_rx_meta;
    logic            r_rx_sync;

    // Synchronizer resets to the idle line level so reset never looks like a start bit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= bus.rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_s     <= '0;
            r_n     <= '0;
            r_b     <= '0;
            r_dout  <= '0;
            r_done  <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_s     <= w_s_next;
            r_n     <= w_n_next;
            r_b     <= w_b_next;
            r_dout  <= w_dout_next;
            r_done  <= w_done_next;
            r_ferr  <= w_ferr_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_s_next     = r_s;
        w_n_next     = r_n;
        w_b_next     = r_b;
        w_dout_next  = r_dout;
        w_done_next  = 1'b0;
        w_ferr_next  = 1'b0;
        unique case (r_state)
            // Start detection runs every clk so the tick phase does not delay it
            ST_IDLE: begin
                if (!r_rx_sync) begin
                    w_s_next     = '0;
                    w_state_next = ST_START;
                end
            end
            ST_START: begin
                if (bus.s_tick) begin
                    if (r_s == c_s_mid) begin
                        w_s_next     = '0;
                        w_n_next     = '0;
                        w_state_next = r_rx_sync ? ST_IDLE : ST_DATA;
                    end else begin
                        w_s_next = r_s + 5'd1;
                    end
                end
            end
            ST_DATA: begin
                if (bus.s_tick) begin
                    if (r_s == c_s_bit) begin
                        w_s_next = '0;
                        w_b_next = {r_rx_sync, r_b[DBIT-1:1]};
                        if (r_n == c_n_last) begin
                            w_state_next = ST_STOP;
                        end else begin
                            w_n_next = r_n + 3'd1;
                        end
                    end else begin
                        w_s_next = r_s + 5'd1;
                    end
                end
            end
            ST_STOP: begin
                if (bus.s_tick) begin
                    if (r_s == c_s_stop) begin
                        w_dout_next  = r_b;
                        w_done_next  = 1'b1;
                        w_ferr_next  = ~r_rx_sync;
                        w_state_next = ST_IDLE;
                    end else begin
                        w_s_next = r_s + 5'd1;
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign bus.rx_dout      = r_dout;
    assign bus.rx_done_tick = r_done;
    assign bus.frame_err    = r_ferr;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Purpose  : Directed self-checking bench for uart_rx, incl. a transmit model.
// Revision : 1.0
// ============================================================================
module tb_uart_rx;

    localparam int DBIT    = 8;
    localparam int SB_TICK = 16;

    logic clk;
    logic reset;
    int   tick_div;
    int   tick_cnt;

    int   checks;
    int   errors;
    int   done_count;
    int   ferr_count;
    int   long_pulse;
    int   stray_ferr;
    logic prev_done;
    logic [7:0] last_dout;
    logic       last_ferr;

    uart_rx_if #(.DBIT(DBIT)) bus ();

    uart_rx #(
        .DBIT    (DBIT),
        .SB_TICK (SB_TICK)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // s_tick generator, updated on the falling edge so it is stable at posedge
    always @(negedge clk) begin
        if (tick_cnt >= tick_div - 1) begin
            tick_cnt   = 0;
            bus.s_tick = 1'b1;
        end else begin
            tick_cnt   = tick_cnt + 1;
            bus.s_tick = 1'b0;
        end
    end

    // Output monitor: records pulses between directed checks
    always @(negedge clk) begin
        if (bus.rx_done_tick === 1'b1) begin
            done_count = done_count + 1;
            last_dout  = bus.rx_dout;
            last_ferr  = bus.frame_err;
            if (bus.frame_err === 1'b1) ferr_count = ferr_count + 1;
            if (prev_done === 1'b1) long_pulse = long_pulse + 1;
        end else if (bus.frame_err !== 1'b0 && reset === 1'b0) begin
            stray_ferr = stray_ferr + 1;
        end
        prev_done = bus.rx_done_tick;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        int k;
        k = 0;
        while (k < n) begin
            @(posedge clk);
            if (bus.s_tick === 1'b1) k = k + 1;
        end
        #1;
    endtask

    // Transmit model: start bit, DBIT data bits LSB first, stop bit of stop_ticks ticks
    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int stop_ticks);
        bus.rx = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < DBIT; i++) begin
            bus.rx = d[i];
            wait_ticks(16);
        end
        bus.rx = stop_bit;
        wait_ticks(stop_ticks);
        bus.rx = 1'b1;
    endtask

    int         base;
    logic [7:0] rnd;

    initial begin
        checks     = 0;
        errors     = 0;
        done_count = 0;
        ferr_count = 0;
        long_pulse = 0;
        stray_ferr = 0;
        prev_done  = 1'b0;
        last_dout  = '0;
        last_ferr  = 1'b0;
        tick_div   = 4;
        tick_cnt   = 0;
        bus.s_tick = 1'b0;
        bus.rx     = 1'b1;
        reset      = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_dout", 32'(bus.rx_dout), 32'h0);
        check("reset_done", 32'(bus.rx_done_tick), 32'h0);
        check("reset_ferr", 32'(bus.frame_err), 32'h0);
        reset = 1'b0;
        wait_ticks(20);

        // Nominal frame
        base = done_count;
        send_frame(8'h55, 1'b1, 16);
        wait_ticks(4);
        check("f55_count", 32'(done_count - base), 32'd1);
        check("f55_dout", 32'(last_dout), 32'h55);
        check("f55_ferr", 32'(last_ferr), 32'h0);
        check("f55_hold", 32'(bus.rx_dout), 32'h55);

        // Short low glitch is rejected at the mid-start sample
        base = done_count;
        bus.rx = 1'b0;
        wait_ticks(4);
        bus.rx = 1'b1;
        wait_ticks(24);
        check("glitch_count", 32'(done_count - base), 32'd0);
        check("glitch_dout", 32'(bus.rx_dout), 32'h55);

        // Low stop bit, released before the next mid-start so no extra frame follows
        base = done_count;
        send_frame(8'hA3, 1'b0, 12);
        wait_ticks(24);
        check("fA3_count", 32'(done_count - base), 32'd1);
        check("fA3_dout", 32'(last_dout), 32'hA3);
        check("fA3_ferr", 32'(last_ferr), 32'h1);

        // Back-to-back frames
        base = done_count;
        send_frame(8'h00, 1'b1, 16);
        check("b2b0_count", 32'(done_count - base), 32'd1);
        check("b2b0_dout", 32'(last_dout), 32'h00);
        check("b2b0_ferr", 32'(last_ferr), 32'h0);
        send_frame(8'hFF, 1'b1, 16);
        wait_ticks(4);
        check("b2b1_count", 32'(done_count - base), 32'd2);
        check("b2b1_dout", 32'(last_dout), 32'hFF);
        check("b2b1_ferr", 32'(last_ferr), 32'h0);

        // Break: two 152-tick frames fit in 308 low ticks, the third is rejected
        base = done_count;
        bus.rx = 1'b0;
        wait_ticks(308);
        bus.rx = 1'b1;
        wait_ticks(30);
        check("brk_count", 32'(done_count - base), 32'd2);
        check("brk_ferrs", 32'(ferr_count), 32'd3);
        check("brk_dout", 32'(last_dout), 32'h00);
        check("brk_ferr", 32'(last_ferr), 32'h1);

        // Reset in the middle of data bit 3
        send_frame(8'hFF, 1'b1, 16);
        wait_ticks(4);
        check("pre_rst_dout", 32'(bus.rx_dout), 32'hFF);
        base = done_count;
        bus.rx = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 3; i++) begin
            bus.rx = 1'b1;
            wait_ticks(16);
        end
        bus.rx = 1'b0;
        wait_ticks(8);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("rst_dout", 32'(bus.rx_dout), 32'h0);
        check("rst_done", 32'(bus.rx_done_tick), 32'h0);
        check("rst_ferr", 32'(bus.frame_err), 32'h0);
        bus.rx = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b0;
        wait_ticks(200);
        check("rst_nodone", 32'(done_count - base), 32'd0);
        send_frame(8'h3C, 1'b1, 16);
        wait_ticks(4);
        check("f3C_count", 32'(done_count - base), 32'd1);
        check("f3C_dout", 32'(last_dout), 32'h3C);
        check("f3C_ferr", 32'(last_ferr), 32'h0);

        // Loopback from the transmit model with s_tick on every clk
        tick_div = 1;
        wait_ticks(20);
        for (int j = 0; j < 256; j++) begin
            rnd  = 8'($urandom_range(0, 255));
            base = done_count;
            send_frame(rnd, 1'b1, SB_TICK);
            check("lb_count", 32'(done_count - base), 32'd1);
            check("lb_dout", 32'(last_dout), 32'(rnd));
            check("lb_ferr", 32'(last_ferr), 32'h0);
        end
        wait_ticks(20);

        check("pulse_width", 32'(long_pulse), 32'd0);
        check("stray_ferr", 32'(stray_ferr), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL take parameter DBIT, default 8, as the number of data bits per frame (legal 5..8).
REQ-002 The block SHALL take parameter SB_TICK, default 16, as the number of s_tick periods in the stop bit (legal 16, 24, 32).
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-004 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port s_tick, input, 1 bit: one-clk enable pulse at 16x the baud rate.
REQ-007 The block SHALL have port rx, input, 1 bit: asynchronous serial line, which idles high.
REQ-008 The block SHALL have port rx_dout, output, DBIT bits: last received data word, LSB first on the line.
REQ-009 The block SHALL have port rx_done_tick, output, 1 bit: one-clk pulse when a frame completes.
REQ-010 The block SHALL have port frame_err, output, 1 bit: valid only while rx_done_tick=1; 1 = stop bit sampled low.

Function
REQ-011 The block SHALL pass rx through a 2-flop synchronizer (rx_sync), adding 2 clk of latency, and SHALL sample only rx_sync.
REQ-012 The block SHALL hold counters s_reg (5 bit, tick count), n_reg (3 bit, bit index) and b_reg (DBIT bits, shift register).
REQ-013 The state machine SHALL have the states idle, start, data and stop, and SHALL change state, counters or b_reg only on s_tick, except for the idle->start transition.
REQ-014 In idle, when rx_sync=0 on any clk, with or without s_tick, the block SHALL clear s_reg and go to start.
REQ-015 In start, when s_tick=1 and s_reg=7 (mid start bit), the block SHALL clear s_reg and n_reg and go to data if rx_sync=0, or go to idle if rx_sync=1 (glitch reject, no rx_done_tick).
REQ-016 In start, when s_tick=1 and s_reg<7, the block SHALL increment s_reg.
REQ-017 In data, when s_tick=1 and s_reg=15, the block SHALL clear s_reg and set b_reg to {rx_sync, b_reg[DBIT-1:1]}; it SHALL go to stop if n_reg=DBIT-1, else increment n_reg.
REQ-018 In data, when s_tick=1 and s_reg<15, the block SHALL increment s_reg.
REQ-019 In stop, when s_tick=1 and s_reg=SB_TICK-1, the block SHALL, on the next clk edge, load rx_dout with b_reg, pulse rx_done_tick for exactly 1 clk, drive frame_err to ~rx_sync, and go to idle.
REQ-020 In stop, when s_tick=1 and s_reg<SB_TICK-1, the block SHALL increment s_reg.
REQ-021 The block SHALL hold rx_dout between frames, and SHALL hold frame_err at 0 whenever rx_done_tick=0.
REQ-022 On a frame with a framing error, the block SHALL still update rx_dout and pulse rx_done_tick.
REQ-023 When rx is held low continuously (break), the block SHALL produce back-to-back frames of data 0 with frame_err=1, each started from idle on the clk after the previous done.
REQ-024 When s_tick is absent, the block SHALL hold all state and counters unchanged.
REQ-025 A new start edge arriving in the same clk as rx_done_tick SHALL be detected in idle on the following clk.
REQ-026 The block SHALL sample each data bit 16 ticks after the previous sample, and the first data bit 16 ticks after the mid-start sample.

Reset
REQ-027 Asserting reset SHALL immediately force state=idle; s_reg, n_reg, b_reg, rx_dout, rx_done_tick and frame_err to 0; and both synchronizer flops to 1.
REQ-028 Reset asserted mid-frame SHALL abort the frame with no rx_done_tick, and the first frame after reset deassertion SHALL be received normally.

Verification
REQ-029 The bench SHALL cover: s_tick every 4 clk, frame 0x55 with a high stop bit -> rx_dout=0x55, single 1-clk rx_done_tick, frame_err=0.
REQ-030 The bench SHALL cover: rx low for 4 ticks then high -> return to idle, no rx_done_tick, rx_dout unchanged.
REQ-031 The bench SHALL cover: frame 0xA3 with a low stop bit -> rx_dout=0xA3, rx_done_tick=1 with frame_err=1.
REQ-032 The bench SHALL cover: back-to-back frames 0x00 then 0xFF, 1 stop bit each -> two rx_done_tick pulses, values 0x00 then 0xFF, frame_err=0 both.
REQ-033 The bench SHALL cover: reset pulse during data bit 3 -> all outputs 0, no done pulse; next frame 0x3C -> rx_dout=0x3C.
REQ-034 The bench SHALL cover: loopback from uart_tx (same DBIT/SB_TICK, shared s_tick), 256 random bytes -> every byte matches, frame_err=0 throughout.
